ripple_adder_multicycle: RTL and testbench
==========================================

# ripple_adder_multicycle

Parametrised multi-cycle ripple-carry adder. It adds two WIDTH-bit operands plus a carry-in, processing CHUNK bits per clock and carrying the ripple between chunks in a register. It is the sequential, width-generic successor to the team's 4-bit structural ripple adder, and is used where a full-width combinational carry chain will not meet timing. A start/busy/done handshake delivers registered results, and it also flags signed overflow.

## Interface
- WIDTH, 16: operand and sum width in bits; must be ≥ 1.
- CHUNK, 4: bits added per cycle; must satisfy 1 ≤ CHUNK ≤ WIDTH and WIDTH % CHUNK == 0.
- Derived constant NCYC = WIDTH / CHUNK: cycles per operation.

One clock; reset is asynchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request an operation; sampled only while busy = 0
- a  in  WIDTH  operand A, captured at start acceptance
- b  in  WIDTH  operand B, captured at start acceptance
- carry_in  in  1  carry into bit 0, captured at start acceptance
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: result outputs updated this cycle
- sum  out  WIDTH  registered sum, held until the next completion
- carry_out  out  1  unsigned carry out of bit WIDTH-1
- overflow  out  1  two's-complement signed overflow

## Operation
- FSM states: IDLE and RUN. The reset state is IDLE.
- IDLE, start = 1 at an edge: latch a, b and carry_in into operand registers. Set chunk counter = 0 and carry register = carry_in. Go to RUN and set busy = 1.
- IDLE, start = 0: no state change. Outputs hold.
- RUN, each edge: chunk index i = counter.
  - Compute {c, s} = a_q[i*CHUNK +: CHUNK] + b_q[i*CHUNK +: CHUNK] + carry_q.
  - Write s into the shadow sum at chunk i. Carry register ← c. Counter increments.
- RUN, edge processing chunk NCYC-1:
  - Publish the shadow sum (including this chunk) to sum.
  - carry_out ← final c.
  - overflow ← (a_q[W-1] == b_q[W-1]) && (sum_new[W-1] != a_q[W-1]).
  - done ← 1, busy ← 0, return to IDLE.
- start while busy = 1 is ignored and not queued.
- Changes on a, b or carry_in after acceptance have no effect on the operation in flight.
- Results are modulo 2^WIDTH; carry_out is the 2^WIDTH bit.
- Reset in any state:
  - State → IDLE; counter and carry register → 0.
  - busy = 0, done = 0, sum = 0, carry_out = 0, overflow = 0.
  - An in-flight operation is abandoned, and no done is produced for it.

## Timing
- Start accepted at edge E0: busy goes high after E0.
- Chunks are processed at edges E1..E_NCYC.
- done, busy = 0 and the new sum / carry_out / overflow are all visible after E_NCYC. Latency is NCYC cycles from the acceptance edge.
- done is high for exactly one cycle. It is low during reset and on every non-completion cycle.
- Back-to-back: start held high during the done cycle is accepted at E_NCYC+1. Peak throughput is one operation per NCYC+1 cycles.
- NCYC = 1 (CHUNK = WIDTH): busy for one cycle, done one cycle after acceptance.
- Outputs between completions are stable, with no partial-sum glitches; the shadow register is internal.
- The counter is ceil(log2(NCYC))-bit, minimum 1 bit. It never exceeds NCYC-1.

## Structure
- Package adder_pkg:
  - state enum (IDLE, RUN)
  - function computing the counter width from NCYC
  - parameter legality check (elaboration-time error if WIDTH % CHUNK != 0)
- Sub-module ripple_chunk_adder: a purely combinational CHUNK-bit ripple of full adders (in a, b, cin; out s, cout), instantiated once.
- Top-level module: the FSM, counter, operand, carry, shadow and output registers.

## Test plan
All scenarios use WIDTH = 16, CHUNK = 4 unless stated.
- Reset: assert rst mid-cycle → busy, done, sum, carry_out, overflow all 0 immediately (asynchronous), before any clock edge.
- Basic add: a = 0x0003, b = 0x0006, carry_in = 0, start pulse → done exactly 4 cycles after acceptance; sum = 0x0009, carry_out = 0, overflow = 0; sum holds afterwards.
- Full ripple: a = 0xFFFF, b = 0x0000, carry_in = 1 → sum = 0x0000, carry_out = 1, overflow = 0. Separately, a = 0x7FFF, b = 0x0001 → sum = 0x8000, carry_out = 0, overflow = 1.
- Handshake:
  - start re-pulsed during RUN is ignored; exactly one done is produced.
  - a/b changed during RUN do not alter the result.
  - start held through the done cycle gives a second result 5 cycles after the first done.
- Reset mid-operation: rst during the 2nd RUN cycle → no done. A following op 0x1234 + 0x4321 gives sum = 0x5555 with normal latency.
- Degenerate configuration: CHUNK = WIDTH = 8, a = 0x80, b = 0x80 → done 1 cycle after acceptance; sum = 0x00, carry_out = 1, overflow = 1.

Source files
------------

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and elaboration helpers for the multi-cycle ripple adder
package adder_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Counter must hold 0..ncyc-1, and is never narrower than one bit.
   function automatic int cnt_width(input int ncyc);
      return (ncyc <= 1) ? 1 : $clog2(ncyc);
   endfunction

   function automatic bit params_ok(input int width, input int chunk);
      return (width >= 1) && (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
   endfunction

endpackage

// File: rtl/ripple_chunk_adder.sv
// rtl/ripple_chunk_adder.sv - combinational W-bit ripple of full adders
module ripple_chunk_adder #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cout
);

   logic [W:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < W; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[W];

endmodule

// File: rtl/ripple_adder_multicycle.sv
// rtl/ripple_adder_multicycle.sv - sequential adder, CHUNK bits per clock with registered ripple carry
module ripple_adder_multicycle
   import adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   localparam int NCYC = WIDTH / CHUNK;
   localparam int CW   = cnt_width(NCYC);
   localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

   if (!params_ok(WIDTH, CHUNK)) begin : g_bad_params
      $error("ripple_adder_multicycle: illegal WIDTH/CHUNK combination");
   end

   state_t           state;
   state_t           state_next;
   logic [CW-1:0]    cnt;
   logic             carry_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] shadow;
   logic [WIDTH-1:0] shadow_next;
   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic [CHUNK-1:0] s_chunk;
   logic             c_chunk;
   logic             accept;
   logic             step;
   logic             last;
   int               idx;

   always_comb begin
      idx         = int'(cnt) * CHUNK;
      a_chunk     = a_q[idx +: CHUNK];
      b_chunk     = b_q[idx +: CHUNK];
      shadow_next = shadow;
      shadow_next[idx +: CHUNK] = s_chunk;
   end

   ripple_chunk_adder #(.W(CHUNK)) u_chunk (
      .a    (a_chunk),
      .b    (b_chunk),
      .cin  (carry_q),
      .s    (s_chunk),
      .cout (c_chunk)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      step       = 1'b0;
      last       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt == LAST) begin
               last       = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs only change on the final chunk; intermediate chunks live in shadow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         carry_q   <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         shadow    <= '0;
         sum       <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= carry_in;
            cnt     <= '0;
         end
         if (step) begin
            shadow  <= shadow_next;
            carry_q <= c_chunk;
            cnt     <= last ? '0 : cnt + CW'(1);
         end
         if (last) begin
            sum       <= shadow_next;
            carry_out <= c_chunk;
            overflow  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (shadow_next[WIDTH-1] != a_q[WIDTH-1]);
            done      <= 1'b1;
         end
      end
   end

   assign busy = (state == RUN);

endmodule

// File: tb/tb_ripple_adder_multicycle.sv
// tb/tb_ripple_adder_multicycle.sv - scoreboard bench for ripple_adder_multicycle
module tb_ripple_adder_multicycle;

   localparam int NCYC = 4;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        carry_in;
   logic        busy;
   logic        done;
   logic [15:0] sum;
   logic        carry_out;
   logic        overflow;

   logic        start8;
   logic [7:0]  a8;
   logic [7:0]  b8;
   logic        ci8;
   logic        busy8;
   logic        done8;
   logic [7:0]  sum8;
   logic        co8;
   logic        ov8;

   ripple_adder_multicycle #(.WIDTH(16), .CHUNK(4)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .carry_in(carry_in),
      .busy(busy), .done(done), .sum(sum), .carry_out(carry_out), .overflow(overflow)
   );

   ripple_adder_multicycle #(.WIDTH(8), .CHUNK(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .carry_in(ci8),
      .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8), .overflow(ov8)
   );

   typedef struct {
      logic [15:0] s;
      logic        co;
      logic        ov;
      int          acc;
   } exp_t;

   exp_t        exp_q[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          prev_done = 0;
   int          last_done = 0;
   logic [15:0] held_s = '0;
   logic        held_co = 1'b0;
   logic        held_ov = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Reference: plain integer arithmetic, signed range test for overflow.
   function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv, input logic ci, input int acc);
      exp_t        e;
      int          us;
      int          ss;
      logic [31:0] usv;
      us    = int'(av) + int'(bv) + int'(ci);
      ss    = int'($signed(av)) + int'($signed(bv)) + int'(ci);
      usv   = us;
      e.s   = usv[15:0];
      e.co  = (us > 65535);
      e.ov  = (ss > 32767) || (ss < -32768);
      e.acc = acc;
      return e;
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (done) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", 32'(done), 32'(0));
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("sum", 32'(sum), 32'(e.s));
               check("carry_out", 32'(carry_out), 32'(e.co));
               check("overflow", 32'(overflow), 32'(e.ov));
               check("latency", 32'(cyc - e.acc), 32'(NCYC));
               held_s    = e.s;
               held_co   = e.co;
               held_ov   = e.ov;
               prev_done = last_done;
               last_done = cyc;
            end
         end else begin
            check("hold", {15'd0, held_s, held_co, held_ov}, {15'd0, sum, carry_out, overflow});
         end
      end
   end

   task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                        input bit repulse, input bit scramble);
      int n = 0;
      @(negedge clk);
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         check("issue_timeout", 32'(busy), 32'(0));
         return;
      end
      a        = av;
      b        = bv;
      carry_in = ci;
      start    = 1'b1;
      @(posedge clk);
      #1;
      exp_q.push_back(model(av, bv, ci, cyc));
      for (int k = 0; k < NCYC; k++) begin
         @(negedge clk);
         start = repulse && busy;
         if (scramble) begin
            a        = 16'($urandom);
            b        = 16'($urandom);
            carry_in = 1'($urandom);
         end
      end
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'(0));
   endtask

   initial begin
      int us8;
      int ss8;
      rst      = 1'b1;
      start    = 1'b0;
      a        = '0;
      b        = '0;
      carry_in = 1'b0;
      start8   = 1'b0;
      a8       = '0;
      b8       = '0;
      ci8      = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_outputs", {27'd0, busy, done, carry_out, overflow, 1'b0} | 32'(sum), 32'(0));
      rst = 1'b0;

      issue(16'h0003, 16'h0006, 1'b0, 1'b0, 1'b0);
      start = 1'b0;
      drain();
      repeat (3) @(negedge clk);
      check("basic_hold", 32'(sum), 32'h0009);

      issue(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
      start = 1'b0;
      issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
      start = 1'b0;
      drain();

      // Asynchronous reset mid-cycle, observed before the next rising edge.
      @(negedge clk);
      #2;
      rst = 1'b1;
      exp_q.delete();
      held_s  = '0;
      held_co = 1'b0;
      held_ov = 1'b0;
      #1;
      check("async_rst_sum", 32'(sum), 32'(0));
      check("async_rst_flags", {28'd0, busy, done, carry_out, overflow}, 32'(0));
      @(negedge clk);
      #1;
      rst = 1'b0;

      issue(16'($urandom), 16'($urandom), 1'b0, 1'b1, 1'b1);
      start = 1'b0;
      drain();
      issue(16'h1357, 16'h2468, 1'b1, 1'b1, 1'b1);
      start = 1'b0;
      drain();

      issue(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
      issue(16'h00FF, 16'h0F01, 1'b1, 1'b0, 1'b0);
      start = 1'b0;
      drain();
      check("b2b_gap", 32'(last_done - prev_done), 32'(NCYC + 1));

      // Reset during the second RUN cycle abandons the operation.
      @(negedge clk);
      a        = 16'h1111;
      b        = 16'h2222;
      carry_in = 1'b0;
      start    = 1'b1;
      @(posedge clk);
      #1;
      exp_q.push_back(model(16'h1111, 16'h2222, 1'b0, cyc));
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      held_s  = '0;
      held_co = 1'b0;
      held_ov = 1'b0;
      @(negedge clk);
      #1;
      check("midrst_busy", 32'(busy), 32'(0));
      rst = 1'b0;
      repeat (6) @(negedge clk);
      issue(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
      start = 1'b0;
      drain();
      check("after_midrst_sum", 32'(sum), 32'h5555);

      for (int i = 0; i < 40; i++) begin
         int gap;
         issue(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         gap = $urandom_range(0, 2);
         if (gap != 0) begin
            start = 1'b0;
            repeat (gap) @(negedge clk);
         end
      end
      start = 1'b0;
      drain();

      // Single-chunk configuration: done one cycle after acceptance.
      for (int t = 0; t < 3; t++) begin
         logic [7:0] av8;
         logic [7:0] bv8;
         logic       cv8;
         av8 = (t == 0) ? 8'h80 : 8'($urandom);
         bv8 = (t == 0) ? 8'h80 : 8'($urandom);
         cv8 = (t == 0) ? 1'b0 : 1'($urandom);
         us8 = int'(av8) + int'(bv8) + int'(cv8);
         ss8 = int'($signed(av8)) + int'($signed(bv8)) + int'(cv8);
         @(negedge clk);
         a8     = av8;
         b8     = bv8;
         ci8    = cv8;
         start8 = 1'b1;
         @(posedge clk);
         #1;
         start8 = 1'b0;
         check("deg_busy", {30'd0, busy8, done8}, 32'b10);
         @(posedge clk);
         #1;
         check("deg_done", {30'd0, busy8, done8}, 32'b01);
         check("deg_sum", 32'(sum8), 32'(us8 % 256));
         check("deg_co", 32'(co8), 32'(us8 > 255));
         check("deg_ov", 32'(ov8), 32'((ss8 > 127) || (ss8 < -128)));
         @(posedge clk);
         #1;
         check("deg_done_pulse", 32'(done8), 32'(0));
         check("deg_hold", 32'(sum8), 32'(us8 % 256));
      end

      drain();
      repeat (3) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
